// File: rtl/risc_alu_pkg.sv
// Shared opcode/state types and op-class helpers for the multi-cycle ALU.
package risc_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLL   = 4'd4,
        OP_SRL   = 4'd5,
        OP_XOR   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIV   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_REM   = 4'd14,
        OP_REMU  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic logic is_iterative(alu_op_e op);
        return op >= OP_MUL;
    endfunction

    function automatic logic is_div(alu_op_e op);
        return op >= OP_DIV;
    endfunction

endpackage

// File: rtl/risc_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one acc/lo register pair.
module risc_muldiv_iter
    import risc_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  acc, lo, opnd, acc_n, lo_n, diff, mag_a, mag_b;
    logic [XLEN:0]    sum, shifted;
    logic [CNT_W-1:0] cnt;
    logic             busy, is_mul, ge, signed_op, sa, sb, neg_q, neg_r;
    alu_op_e          op_r;

    // Signed div/rem run on magnitudes; signs are reapplied on the last step.
    assign signed_op = (op == OP_DIV) || (op == OP_REM);
    assign sa        = signed_op && a[XLEN-1];
    assign sb        = signed_op && b[XLEN-1];
    assign mag_a     = sa ? -a : a;
    assign mag_b     = sb ? -b : b;

    assign is_mul  = (op_r == OP_MUL) || (op_r == OP_MULHU);
    assign sum     = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    assign shifted = {acc, lo[XLEN-1]};
    assign ge      = shifted >= {1'b0, opnd};
    assign diff    = shifted[XLEN-1:0] - opnd;
    assign done    = busy && (cnt == CNT_W'(XLEN-1));

    always_comb begin
        if (is_mul) begin
            acc_n = sum[XLEN:1];
            lo_n  = {sum[0], lo[XLEN-1:1]};
        end else begin
            acc_n = ge ? diff : shifted[XLEN-1:0];
            lo_n  = {lo[XLEN-2:0], ge};
        end
    end

    always_comb begin
        case (op_r)
            OP_MUL:          result = lo_n;
            OP_MULHU:        result = acc_n;
            OP_DIV, OP_DIVU: result = neg_q ? -lo_n : lo_n;
            default:         result = neg_r ? -acc_n : acc_n;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            lo    <= '0;
            opnd  <= '0;
            op_r  <= OP_ADD;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= '0;
            op_r  <= op;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            if (op == OP_MUL || op == OP_MULHU) begin
                lo   <= b;
                opnd <= a;
            end else begin
                lo   <= mag_a;
                opnd <= mag_b;
            end
        end else if (busy) begin
            acc <= acc_n;
            lo  <= lo_n;
            cnt <= cnt + CNT_W'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/risc_alu_mc.sv
// Multi-cycle integer ALU: one-cycle simple ops, iterative mul/div, valid/ready on both sides.
module risc_alu_mc
    import risc_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [3:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            zero
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e             state;
    alu_op_e            op;
    logic [SHAMT_W-1:0] shamt;
    logic               accept, div_zero, div_ovf, short_div, go_calc, eng_done;
    logic [XLEN-1:0]    quick, eng_result;

    assign op        = alu_op_e'(alu_op);
    assign shamt     = operand_b[SHAMT_W-1:0];
    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign div_zero  = (operand_b == '0);
    assign div_ovf   = (operand_a == MIN_NEG) && (operand_b == '1) && (op == OP_DIV || op == OP_REM);
    // Divide-by-zero and signed overflow have fixed answers, so they skip the engine.
    assign short_div = is_div(op) && (div_zero || div_ovf);
    assign go_calc   = is_iterative(op) && !short_div;

    always_comb begin
        case (op)
            OP_ADD:  quick = operand_a + operand_b;
            OP_SUB:  quick = operand_a - operand_b;
            OP_AND:  quick = operand_a & operand_b;
            OP_OR:   quick = operand_a | operand_b;
            OP_SLL:  quick = operand_a << shamt;
            OP_SRL:  quick = operand_a >> shamt;
            OP_XOR:  quick = operand_a ^ operand_b;
            OP_SRA:  quick = $signed(operand_a) >>> shamt;
            OP_SLT:  quick = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: quick = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            OP_DIV:  quick = div_zero ? '1 : operand_a;
            OP_DIVU: quick = '1;
            OP_REM:  quick = div_zero ? operand_a : '0;
            OP_REMU: quick = operand_a;
            default: quick = '0;
        endcase
    end

    risc_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && go_calc),
        .op     (op),
        .a      (operand_a),
        .b      (operand_b),
        .done   (eng_done),
        .result (eng_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            alu_out <= '0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        zero <= (operand_a == operand_b);
                        if (go_calc) begin
                            state <= CALC;
                        end else begin
                            state   <= DONE;
                            alu_out <= quick;
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (eng_done) begin
                        state   <= DONE;
                        alu_out <= eng_result;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_alu_mc.sv
// Scenario bench for risc_alu_mc (XLEN=32): expected results queued at drive time, popped at output.
module tb_risc_alu_mc;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            zero;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic            in_ready, out_valid, zero;
    logic [XLEN-1:0] operand_a = '0, operand_b = '0, alu_out;
    logic [3:0]      alu_op = '0;
    int              checks = 0, failures = 0;
    exp_t            exp_q[$];

    risc_alu_mc #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        p   = {32'b0, a} * {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a << b[4:0];
            4'd5:  return a >> b[4:0];
            4'd6:  return a ^ b;
            4'd7:  return $signed(a) >>> b[4:0];
            4'd8:  return {31'b0, $signed(a) < $signed(b)};
            4'd9:  return {31'b0, a < b};
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        in_valid  = 1'b1;
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        exp_q.push_back('{res: res, zero: (a == b)});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || alu_out !== '0 || zero !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: valid=%b out=%h zero=%b ready=%b, want 0/0/0/1", out_valid, alu_out, zero, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_simple();
        vec_t v[11];
        exp_t e;
        logic [3:0]  op;
        logic [31:0] a, b, r;
        v = '{'{4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE},
              '{4'd7, 32'h8000_0000, 32'h24, 32'hF800_0000},
              '{4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1},
              '{4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0},
              '{4'd0, 32'd3, 32'd4, 32'd7},
              '{4'd0, 32'd9, 32'd9, 32'd18},
              '{4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000},
              '{4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0},
              '{4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555},
              '{4'd4, 32'd1, 32'h3F, 32'h8000_0000},
              '{4'd5, 32'h8000_0000, 32'h21, 32'h4000_0000}};
        out_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (i < 11) begin
                op = v[i].op; a = v[i].a; b = v[i].b; r = v[i].res;
            end else begin
                op = 4'($urandom_range(0, 9)); a = $urandom; b = $urandom;
                if (i == 12) b = a;
                r = model(op, a, b);
            end
            drive(op, a, b, r);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL simple_ready[%0d]: ready=%b want 1", i, in_ready);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || alu_out !== e.res || zero !== e.zero) begin
                failures++;
                $display("FAIL simple_result[%0d] op=%0d: valid=%b out=%h zero=%b, want 1/%h/%b", i, op, out_valid, alu_out, zero, e.res, e.zero);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL simple_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_iterative();
        vec_t v[6];
        exp_t e;
        logic [3:0]  op;
        logic [31:0] a, b, r;
        int          lat;
        logic        busy_bad;
        v = '{'{4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0},
              '{4'd11, 32'h0001_0000, 32'h0001_0000, 32'h1},
              '{4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD},
              '{4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
              '{4'd13, 32'd100, 32'd7, 32'd14},
              '{4'd15, 32'd100, 32'd7, 32'd2}};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                op = v[i].op; a = v[i].a; b = v[i].b; r = v[i].res;
            end else begin
                op = 4'($urandom_range(10, 15)); a = $urandom;
                b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 5000));
                if (i == 7) b = -32'd13;
                if (b == 0) b = 32'd3;
                if (a == 32'h8000_0000) a = 32'd1;
                r = model(op, a, b);
            end
            drive(op, a, b, r);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            busy_bad = 1'b0;
            while (out_valid !== 1'b1 && lat < 100) begin
                if (in_ready !== 1'b0) busy_bad = 1'b1;
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (busy_bad) begin
                failures++;
                $display("FAIL calc_ready[%0d]: in_ready rose during CALC, want 0", i);
            end
            checks++;
            if (lat != 32) begin
                failures++;
                $display("FAIL iter_latency[%0d] op=%0d: got %0d cycles want 32", i, op, lat);
            end
            e = exp_q.pop_front();
            checks++;
            if (alu_out !== e.res || zero !== e.zero) begin
                failures++;
                $display("FAIL iter_result[%0d] op=%0d a=%h b=%h: out=%h zero=%b want %h/%b", i, op, a, b, alu_out, zero, e.res, e.zero);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_corner();
        vec_t v[6];
        exp_t e;
        int   lat;
        v = '{'{4'd13, 32'd9, 32'd0, 32'hFFFF_FFFF},
              '{4'd14, 32'd9, 32'd0, 32'd9},
              '{4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
              '{4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
              '{4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF},
              '{4'd15, 32'd7, 32'd0, 32'd7}};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].res);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            while (out_valid !== 1'b1 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat != 0) begin
                failures++;
                $display("FAIL corner_latency[%0d]: got %0d extra cycles want 0", i, lat);
            end
            e = exp_q.pop_front();
            checks++;
            if (alu_out !== e.res || zero !== e.zero) begin
                failures++;
                $display("FAIL corner_result[%0d] op=%0d: out=%h zero=%b want %h/%b", i, v[i].op, alu_out, zero, e.res, e.zero);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        drive(4'd0, 32'd3, 32'd3, 32'd6);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        drive(4'd6, 32'hF0, 32'h0F, 32'hFF);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || alu_out !== e.res || zero !== e.zero || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b out=%h zero=%b ready=%b want 1/%h/%b/0", k, out_valid, alu_out, zero, in_ready, e.res, e.zero);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready: ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || alu_out !== e.res || zero !== e.zero) begin
            failures++;
            $display("FAIL bp_same_edge: valid=%b out=%h zero=%b want 1/%h/%b", out_valid, alu_out, zero, e.res, e.zero);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || alu_out !== e.res) begin
            failures++;
            $display("FAIL bp_hold2: valid=%b out=%h want 1/%h", out_valid, alu_out, e.res);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic stray;
        out_ready = 1'b1;
        drive(4'd12, 32'd1000, 32'd1000, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || alu_out !== '0 || zero !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state: valid=%b out=%h zero=%b ready=%b want 0/0/0/1", out_valid, alu_out, zero, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(4'd0, 32'd3, 32'd4, 32'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || alu_out !== e.res || zero !== e.zero) begin
            failures++;
            $display("FAIL midreset_add: valid=%b out=%h zero=%b want 1/%h/%b", out_valid, alu_out, zero, e.res, e.zero);
        end
        stray = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL midreset_stray: out_valid rose after discarded op, want 0");
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_iterative();
        test_corner();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
